// File: rtl/board_bus_arbiter.sv
// Two-requester arbiter (CPU, display reader) in front of a memory manager.
// One transaction per four cycles; starvation-bounded CPU priority.
module board_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_wEn,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_dataIn,
    output logic        cpu_gnt,
    output logic        cpu_done,
    output logic [31:0] cpu_dataOut,
    input  logic        dsp_req,
    input  logic [31:0] dsp_addr,
    output logic        dsp_gnt,
    output logic        dsp_done,
    output logic [31:0] dsp_dataOut,
    output logic        mem_wEn,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_dataIn,
    input  logic [31:0] mem_dataOut
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DATA,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        armed;
    logic [3:0]  starve_cnt;
    logic        own_dsp;
    logic        lat_wen;
    logic [31:0] lat_addr;
    logic [31:0] lat_data;
    logic        dsp_wins;

    assign dsp_wins = dsp_req
                    & (~cpu_req | (starve_cnt == LIMIT));

    // armed keeps grants off until the first edge after reset release
    always_comb begin
        state_nx   = state;
        cpu_gnt    = 1'b0;
        dsp_gnt    = 1'b0;
        cpu_done   = 1'b0;
        dsp_done   = 1'b0;
        mem_wEn    = 1'b0;
        mem_addr   = '0;
        mem_dataIn = '0;
        unique case (state)
            IDLE: begin
                if (armed && (cpu_req || dsp_req)) begin
                    cpu_gnt  = ~dsp_wins;
                    dsp_gnt  = dsp_wins;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                mem_addr   = lat_addr;
                mem_dataIn = lat_data;
                mem_wEn    = ~own_dsp & lat_wen;
                state_nx   = DATA;
            end
            DATA: begin
                mem_addr   = lat_addr;
                mem_dataIn = lat_data;
                state_nx   = DONE;
            end
            DONE: begin
                cpu_done = ~own_dsp;
                dsp_done = own_dsp;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            armed       <= 1'b0;
            starve_cnt  <= '0;
            own_dsp     <= 1'b0;
            lat_wen     <= 1'b0;
            lat_addr    <= '0;
            lat_data    <= '0;
            cpu_dataOut <= '0;
            dsp_dataOut <= '0;
        end else begin
            state <= state_nx;
            armed <= 1'b1;
            if (cpu_gnt || dsp_gnt) begin
                own_dsp  <= dsp_gnt;
                lat_wen  <= cpu_gnt & cpu_wEn;
                lat_addr <= dsp_gnt ? dsp_addr : cpu_addr;
                lat_data <= dsp_gnt ? 32'h0 : cpu_dataIn;
            end
            if (dsp_gnt) begin
                starve_cnt <= '0;
            end else if (cpu_gnt && dsp_req) begin
                if (starve_cnt < LIMIT)
                    starve_cnt <= starve_cnt + 4'd1;
            end else if (state == IDLE && !dsp_req) begin
                starve_cnt <= '0;
            end
            // lat_wen is only ever set for CPU writes
            if (state == DATA && !lat_wen) begin
                if (own_dsp)
                    dsp_dataOut <= mem_dataOut;
                else
                    cpu_dataOut <= mem_dataOut;
            end
        end
    end

endmodule
